// File: rtl/text_loader_ctrl_if.sv
// Byte-stream and text-memory write port bundle for the boot-time text loader.
// The slave modport is the loader; master is the host link / memory side.
interface text_loader_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic       mem_rst;

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, mem_we, mem_wdata, mem_rst
   );

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, mem_we, mem_wdata, mem_rst
   );
endinterface

// File: rtl/text_loader_ctrl.sv
// Boot-time sequencer streaming a [4-byte LE length][payload][opt. checksum] image
// into text memory. Optional checksum stage enabled by TEXT_LOADER_CHECKSUM_EN.
module text_loader_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int MAX_BYTES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   text_loader_ctrl_if.slave bus,
   output logic              o_cpuRst,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_bytesLoaded
);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LEN,
      LOAD,
      CHK,
      RUN,
      ERR
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [31:0]       r_length;
   logic [1:0]        r_lenIdx;
   logic [ADDR_W-1:0] r_bytesLoaded;
   logic              r_memWe;
   logic [7:0]        r_memWdata;
`ifdef TEXT_LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;
`endif

   logic        w_xfer;
   logic [31:0] w_lenFull;
   logic        w_lenBad;
   logic        w_lastByte;

   // The length arrives LSB first, so each byte shifts in from the top.
   assign w_xfer     = bus.rx_valid & bus.rx_ready;
   assign w_lenFull  = {bus.rx_data, r_length[31:8]};
   assign w_lenBad   = (w_lenFull == 32'd0) || (w_lenFull[1:0] != 2'b00) ||
                       (w_lenFull > 32'(MAX_BYTES));
   assign w_lastByte = ((32'(r_bytesLoaded) + 32'd1) == r_length);

   // Next-state logic; all status outputs are decoded from state alone so
   // rx_ready never depends on rx_valid.
   always_comb begin
      w_nextState  = r_state;
      bus.rx_ready = 1'b0;
      bus.mem_rst  = 1'b0;
      o_cpuRst     = 1'b1;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_err        = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) w_nextState = CLR;
         end
         CLR: begin
            bus.mem_rst = 1'b1;
            o_busy      = 1'b1;
            w_nextState = LEN;
         end
         LEN: begin
            bus.rx_ready = 1'b1;
            o_busy       = 1'b1;
            if (w_xfer && (r_lenIdx == 2'd3)) w_nextState = w_lenBad ? ERR : LOAD;
         end
         LOAD: begin
            bus.rx_ready = 1'b1;
            o_busy       = 1'b1;
`ifdef TEXT_LOADER_CHECKSUM_EN
            if (w_xfer && w_lastByte) w_nextState = CHK;
`else
            if (w_xfer && w_lastByte) w_nextState = RUN;
`endif
         end
`ifdef TEXT_LOADER_CHECKSUM_EN
         CHK: begin
            bus.rx_ready = 1'b1;
            o_busy       = 1'b1;
            if (w_xfer) w_nextState = ((r_sum + bus.rx_data) == 8'd0) ? RUN : ERR;
         end
`endif
         RUN: begin
            o_cpuRst = 1'b0;
            o_done   = 1'b1;
            if (i_start) w_nextState = CLR;
         end
         ERR: begin
            o_err = 1'b1;
            if (i_start) w_nextState = CLR;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register plus datapath; the write strobe lands one cycle after the
   // transfer, together with the updated byte count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_length      <= 32'd0;
         r_lenIdx      <= 2'd0;
         r_bytesLoaded <= '0;
         r_memWe       <= 1'b0;
         r_memWdata    <= 8'd0;
`ifdef TEXT_LOADER_CHECKSUM_EN
         r_sum         <= 8'd0;
`endif
      end else begin
         r_state <= w_nextState;
         r_memWe <= 1'b0;
         if ((w_nextState == CLR) && (r_state != CLR)) begin
            r_bytesLoaded <= '0;
            r_lenIdx      <= 2'd0;
            r_length      <= 32'd0;
`ifdef TEXT_LOADER_CHECKSUM_EN
            r_sum         <= 8'd0;
`endif
         end
         if ((r_state == LEN) && w_xfer) begin
            r_length <= w_lenFull;
            r_lenIdx <= r_lenIdx + 2'd1;
         end
         if ((r_state == LOAD) && w_xfer) begin
            r_memWe       <= 1'b1;
            r_memWdata    <= bus.rx_data;
            r_bytesLoaded <= r_bytesLoaded + ADDR_W'(1);
`ifdef TEXT_LOADER_CHECKSUM_EN
            r_sum         <= r_sum + bus.rx_data;
`endif
         end
      end
   end

   assign bus.mem_we    = r_memWe;
   assign bus.mem_wdata = r_memWdata;
   assign o_bytesLoaded = r_bytesLoaded;

endmodule
